// File: rtl/act_pkg.sv
// Shared definitions for the activation loader: FSM state encoding, default
// configuration and helpers for derived constants and counter widths.
package act_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } act_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_K      = 3;
  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_STRIDE = 1;

  // Elements in one KxK window (WIN_ELEMS).
  function automatic int win_elems(input int k);
    return k * k;
  endfunction

  // Largest legal window origin along one axis (COL_LIMIT / ROW_LIMIT).
  function automatic int pos_limit(input int extent, input int k);
    return extent - k;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/act_addr_gen.sv
// Address generator for the activation loader: window origin (row/col),
// intra-window read counters (r/c), BRAM address and shadow slot of each read.
// All row/column scaling is done with constant increments, no multiplier.
module act_addr_gen
  import act_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int K      = DEF_K,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          reuse,
  input  logic                          issue,
  input  logic                          advance,
  input  logic [ADDR_W-1:0]             img_base_addr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [cnt_w(K*K)-1:0]         slot,
  output logic                          last_issue,
  output logic                          frame_end,
  output logic                          col_zero
);

  localparam int COL_LIMIT = pos_limit(IMG_W, K);
  localparam int ROW_LIMIT = pos_limit(IMG_H, K);
  localparam int COL_W     = cnt_w(IMG_W);
  localparam int ROW_W     = cnt_w(IMG_H);
  localparam int RC_W      = cnt_w(K);
  localparam int SLOT_W    = cnt_w(win_elems(K));
  localparam logic [RC_W-1:0] C_LAST  = RC_W'(K - 1);
  localparam logic [RC_W-1:0] C_REUSE = RC_W'(K - STRIDE);

  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] row_off_reg;   // row * IMG_W
  logic [ADDR_W-1:0] r_off_reg;     // r * IMG_W
  logic [ROW_W-1:0]  row_reg;
  logic [COL_W-1:0]  col_reg;
  logic [RC_W-1:0]   r_reg;
  logic [RC_W-1:0]   c_reg;
  logic [RC_W-1:0]   c_first_reg;   // first column of each row in this load
  logic [SLOT_W-1:0] slot_reg;
  logic              col_wrap;
  logic              row_wrap;
  logic              at_origin;

  assign col_wrap   = (int'(col_reg) + STRIDE) > COL_LIMIT;
  assign row_wrap   = (int'(row_reg) + STRIDE) > ROW_LIMIT;
  assign at_origin  = (row_reg == '0) && (col_reg == '0);
  assign col_zero   = (col_reg == '0);
  assign frame_end  = col_wrap && row_wrap;
  assign last_issue = (r_reg == C_LAST) && (c_reg == C_LAST);
  assign slot       = slot_reg;
  assign mem_addr   = base_reg + row_off_reg + ADDR_W'(col_reg) + r_off_reg + ADDR_W'(c_reg);

  // Window origin: step right by STRIDE, wrap to next row band, wrap to frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg     <= '0;
      col_reg     <= '0;
      row_off_reg <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col_reg <= '0;
        if (row_wrap) begin
          row_reg     <= '0;
          row_off_reg <= '0;
        end else begin
          row_reg     <= row_reg + ROW_W'(STRIDE);
          row_off_reg <= row_off_reg + ADDR_W'(STRIDE * IMG_W);
        end
      end else begin
        col_reg <= col_reg + COL_W'(STRIDE);
      end
    end
  end

  // Intra-window raster counters; base is captured only for the frame's first window.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg    <= '0;
      r_reg       <= '0;
      c_reg       <= '0;
      c_first_reg <= '0;
      r_off_reg   <= '0;
      slot_reg    <= '0;
    end else if (start) begin
      if (at_origin) begin
        base_reg <= img_base_addr;
      end
      r_reg       <= '0;
      r_off_reg   <= '0;
      c_reg       <= reuse ? C_REUSE : '0;
      c_first_reg <= reuse ? C_REUSE : '0;
      slot_reg    <= reuse ? SLOT_W'(K - STRIDE) : '0;
    end else if (issue) begin
      if (c_reg == C_LAST) begin
        c_reg     <= c_first_reg;
        r_reg     <= r_reg + RC_W'(1);
        r_off_reg <= r_off_reg + ADDR_W'(IMG_W);
        slot_reg  <= slot_reg + SLOT_W'(1) + SLOT_W'(c_first_reg);
      end else begin
        c_reg    <= c_reg + RC_W'(1);
        slot_reg <= slot_reg + SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/activate_loader.sv
// Activation fetch stage: on start_load, reads the next KxK window from BRAM
// into a shadow buffer and commits it to a frozen output window.
// Optional macro ACT_COLUMN_REUSE_EN: windows with col != 0 shift the shadow
// left by STRIDE columns and fetch only the K*STRIDE new elements.
module activate_loader
  import act_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int K      = DEF_K,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_load,
  input  logic [ADDR_W-1:0]        img_base_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [K*K*DATA_W-1:0]    window_data,
  output logic                     activate_ready,
  output logic                     frame_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam int WIN_ELEMS = win_elems(K);
  localparam int SLOT_W    = cnt_w(WIN_ELEMS);

  act_state_t        state_reg, state_next;
  logic              start_acc;
  logic              reuse;
  logic              last_issue;
  logic              frame_end;
  logic              col_zero;
  logic [SLOT_W-1:0] slot;
  logic              rd_pending_reg;
  logic [SLOT_W-1:0] rd_slot_reg;
  logic              overrun_reg;
  logic [DATA_W-1:0] shadow_reg [WIN_ELEMS];
  logic [DATA_W-1:0] window_reg [WIN_ELEMS];

  assign start_acc = (state_reg == IDLE) && start_load;
  assign overrun   = overrun_reg;

`ifdef ACT_COLUMN_REUSE_EN
  assign reuse = !col_zero;
`else
  assign reuse = col_zero & 1'b0;
`endif

  act_addr_gen #(
    .ADDR_W (ADDR_W),
    .K      (K),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .start         (start_acc),
    .reuse         (reuse),
    .issue         (state_reg == FETCH),
    .advance       (state_reg == COMMIT),
    .img_base_addr (img_base_addr),
    .mem_addr      (mem_addr),
    .slot          (slot),
    .last_issue    (last_issue),
    .frame_end     (frame_end),
    .col_zero      (col_zero)
  );

  // State register; reset aborts any load in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next     = state_reg;
    mem_rd_en      = 1'b0;
    busy           = 1'b0;
    activate_ready = 1'b0;
    frame_last     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_load) state_next = FETCH;
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = COMMIT;
      end
      COMMIT: begin
        activate_ready = 1'b1;
        frame_last     = frame_end;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Track which shadow slot the datum returning next cycle belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending_reg <= 1'b0;
      rd_slot_reg    <= '0;
    end else begin
      rd_pending_reg <= (state_reg == FETCH);
      rd_slot_reg    <= slot;
    end
  end

  // Sticky flag for requests that arrive while a load (incl. its commit) is underway.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg <= 1'b0;
    end else if (start_load && (state_reg != IDLE)) begin
      overrun_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN_ELEMS; gi++) begin : g_elem
`ifdef ACT_COLUMN_REUSE_EN
      localparam int SRC = ((gi % K) < (K - STRIDE)) ? gi + STRIDE : gi;
`endif
      // Per-slot shadow capture and commit; the final datum goes straight into the
      // output window so it is complete in the activate_ready cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= '0;
          window_reg[gi] <= '0;
        end else begin
          if (rd_pending_reg && (rd_slot_reg == SLOT_W'(gi))) begin
            shadow_reg[gi] <= mem_rdata;
`ifdef ACT_COLUMN_REUSE_EN
          end else if (start_acc && reuse) begin
            shadow_reg[gi] <= shadow_reg[SRC];
`endif
          end
          if (state_reg == DRAIN) begin
            window_reg[gi] <= (rd_pending_reg && (rd_slot_reg == SLOT_W'(gi))) ?
                              mem_rdata : shadow_reg[gi];
          end
        end
      end
      assign window_data[gi*DATA_W +: DATA_W] = window_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_activate_loader.sv
// Self-checking bench for activate_loader on a 5x5 image, K=3, STRIDE=1.
// Expected windows, addresses, latencies and flags come from a positional
// reference model (origin arithmetic over a memory array).
module tb_activate_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int K      = 3;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int STRIDE = 1;
  localparam int WIN    = K * K;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_load;
  logic [ADDR_W-1:0]     img_base_addr;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_rdata;
  logic [WIN*DATA_W-1:0] window_data;
  logic                  activate_ready;
  logic                  frame_last;
  logic                  busy;
  logic                  overrun;

  logic [DATA_W-1:0]     mem [256];

  int errors = 0;
  int checks = 0;

  // reference model state
  int                    m_row, m_col, m_base;
  logic [WIN*DATA_W-1:0] m_window;
  bit                    m_ovr;

  activate_loader #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .K (K),
    .IMG_W  (IMG_W),  .IMG_H  (IMG_H),  .STRIDE (STRIDE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_load     (start_load),
    .img_base_addr  (img_base_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .window_data    (window_data),
    .activate_ready (activate_ready),
    .frame_last     (frame_last),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  // single-port BRAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIN*DATA_W-1:0] model_window(input int base, input int row, input int col);
    logic [WIN*DATA_W-1:0] v;
    v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*DATA_W +: DATA_W] = mem[(base + (row + r) * IMG_W + col + c) & 255];
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start_load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_row = 0; m_col = 0; m_window = '0; m_ovr = 0;
  endtask

  // Entered just after a negedge; requests one window and checks it end to end.
  task automatic load_window(input string tag, input bit start_in_commit, input int base_in);
    int lat_exp, n, first_c;
    bit reuse, seen, busy_ok, hold_ok, addr_ok, exp_last;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] got_q[$];
    reuse = 0; seen = 0; busy_ok = 1; hold_ok = 1; addr_ok = 1;
`ifdef ACT_COLUMN_REUSE_EN
    reuse = (m_col != 0);
`endif
    if (m_row == 0 && m_col == 0) m_base = base_in;
    first_c = reuse ? K - STRIDE : 0;
    lat_exp = reuse ? K * STRIDE + 2 : K * K + 2;
    for (int r = 0; r < K; r++)
      for (int c = first_c; c < K; c++)
        exp_q.push_back(ADDR_W'(m_base + (m_row + r) * IMG_W + m_col + c));
    exp_last = (m_col + STRIDE > IMG_W - K) && (m_row + STRIDE > IMG_H - K);

    img_base_addr = ADDR_W'(base_in);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    n = 1;
    while (!seen && n <= 40) begin
      if (mem_rd_en) got_q.push_back(mem_addr);
      if (activate_ready) begin
        seen = 1;
      end else begin
        if (busy !== 1'b1) busy_ok = 0;
        if (window_data !== m_window) hold_ok = 0;
        @(negedge clk);
        n++;
      end
    end
    check({tag, " ready"}, seen, 1);
    check({tag, " latency"}, n, lat_exp);
    check({tag, " busy_during"}, busy_ok, 1);
    check({tag, " busy_at_commit"}, busy, 0);
    check({tag, " window_hold"}, hold_ok, 1);
    check({tag, " nreads"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) addr_ok = 0;
    check({tag, " addrs"}, addr_ok, 1);
    if (got_q.size() > 0) check({tag, " first_addr"}, got_q[0], exp_q[0]);
    m_window = model_window(m_base, m_row, m_col);
    check({tag, " window"}, window_data, m_window);
    check({tag, " frame_last"}, frame_last, exp_last);
    if (start_in_commit) begin
      start_load = 1'b1;
      m_ovr = 1;
    end
    if (m_col + STRIDE > IMG_W - K) begin
      m_col = 0;
      if (m_row + STRIDE > IMG_H - K) m_row = 0;
      else m_row += STRIDE;
    end else begin
      m_col += STRIDE;
    end
    @(negedge clk);
    check({tag, " overrun"}, overrun, m_ovr);
    $display("window %s: row=%0d col=%0d latency=%0d reads=%0d data=%0h last=%0b",
             tag, m_row, m_col, n, got_q.size(), window_data, frame_last);
  endtask

  initial begin
    int ready_cnt, first_ready;
    bit rd_ok, rdy_seen;
    rst = 1'b1;
    start_load = 1'b0;
    img_base_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'(i);

    // reset state
    @(negedge clk);
    do_reset();
    check("rst mem_rd_en", mem_rd_en, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst window_data", window_data, 0);
    check("rst activate_ready", activate_ready, 0);
    check("rst frame_last", frame_last, 0);
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);

    // full frame of 9 windows, then a 10th that restarts at origin
    for (int w = 0; w < 10; w++) load_window($sformatf("frame_w%0d", w + 1), 0, 0);

    // overrun: second request at cycle 4 is dropped
    do_reset();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    repeat (3) @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    ready_cnt = 0; first_ready = -1;
    for (int n = 5; n <= 30; n++) begin
      if (activate_ready) begin
        ready_cnt++;
        if (first_ready < 0) first_ready = n;
      end
      @(negedge clk);
    end
    check("ovr ready_count", ready_cnt, 1);
    check("ovr ready_cycle", first_ready, 11);
    check("ovr window", window_data, model_window(0, 0, 0));
    check("ovr sticky", overrun, 1);
    $display("overrun: ready_count=%0d ready_cycle=%0d overrun=%0b", ready_cnt, first_ready, overrun);
    do_reset();
    check("ovr cleared_by_rst", overrun, 0);

    // reset in cycle 5 of a fetch
    load_window("pre_rst", 0, 0);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_row = 0; m_col = 0; m_window = '0; m_ovr = 0;
    rd_ok = 1; rdy_seen = 0;
    check("midrst window_cleared", window_data, 0);
    for (int n = 6; n <= 20; n++) begin
      if (mem_rd_en) rd_ok = 0;
      if (activate_ready) rdy_seen = 1;
      @(negedge clk);
    end
    check("midrst rd_en_low", rd_ok, 1);
    check("midrst no_ready", rdy_seen, 0);
    $display("midrst: rd_en_low=%0b ready_seen=%0b", rd_ok, rdy_seen);
    load_window("post_rst", 0, 0);

    // request in the commit cycle is dropped, the one right after is taken
    do_reset();
    load_window("stable_a", 1, 0);
    load_window("stable_b", 0, 0);

    // randomized contents, base and gaps across more than one frame
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom_range(0, 255));
    for (int w = 0; w < 20; w++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      load_window($sformatf("rnd_w%0d", w), 0, int'($urandom_range(0, 150)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
